// File: rtl/sram_write_buffer.sv
// sram_write_buffer
// Posted-write FIFO between the cache controller and the SRAM controller.
// A write completes upstream one cycle after it is accepted and drains to SRAM later,
// oldest first. A read waits until every buffered write has reached SRAM and then
// passes through, so it always sees all earlier writes.
module sram_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [63:0] rd_data,
  output logic        full,
  output logic        empty,
  output logic        sram_write_en,
  output logic        sram_read_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data64,
  input  logic        sram_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_ISSUE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  logic [31:0]   mem_addr_r [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];

  logic          ready_r;
  logic [63:0]   rd_data_r;
  logic          sram_we_r;
  logic          sram_re_r;
  logic [31:0]   sram_addr_r;
  logic [31:0]   sram_wdata_r;

  logic          sram_we_nxt_s;
  logic          sram_re_nxt_s;
  logic [31:0]   sram_addr_nxt_s;
  logic [31:0]   sram_wdata_nxt_s;

  logic          push_s;
  logic          pop_s;
  logic          rd_done_s;

  // Handshake decode: a pop in the same cycle frees a slot, so a full buffer can still accept.
  always_comb begin
    pop_s     = 1'b0;
    rd_done_s = 1'b0;
    push_s    = 1'b0;
    if (state_r == ST_WR_ISSUE) begin
      pop_s = sram_ready;
    end else begin
      pop_s = 1'b0;
    end
    if (state_r == ST_RD_ISSUE) begin
      rd_done_s = sram_ready;
    end else begin
      rd_done_s = 1'b0;
    end
    if (wr_en && !rd_en && !ready_r && ((count_r != CNT_FULL) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Drain FSM next state and next downstream request; buffered writes drain before a read issues.
  always_comb begin
    state_nxt_s      = state_r;
    sram_we_nxt_s    = sram_we_r;
    sram_re_nxt_s    = sram_re_r;
    sram_addr_nxt_s  = sram_addr_r;
    sram_wdata_nxt_s = sram_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          state_nxt_s      = ST_WR_ISSUE;
          sram_we_nxt_s    = 1'b1;
          sram_addr_nxt_s  = mem_addr_r[rptr_r];
          sram_wdata_nxt_s = mem_data_r[rptr_r];
        end else if (rd_en && !ready_r && !push_s) begin
          state_nxt_s     = ST_RD_ISSUE;
          sram_re_nxt_s   = 1'b1;
          sram_addr_nxt_s = address;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_ISSUE: begin
        if (sram_ready) begin
          state_nxt_s   = ST_IDLE;
          sram_we_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_WR_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (sram_ready) begin
          state_nxt_s   = ST_IDLE;
          sram_re_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_RD_ISSUE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        sram_we_nxt_s = 1'b0;
        sram_re_nxt_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read of them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wptr_r] <= address;
      mem_data_r[wptr_r] <= wdata;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      wptr_r       <= {PW{1'b0}};
      rptr_r       <= {PW{1'b0}};
      count_r      <= CNT_ZERO;
      ready_r      <= 1'b0;
      rd_data_r    <= 64'h0;
      sram_we_r    <= 1'b0;
      sram_re_r    <= 1'b0;
      sram_addr_r  <= 32'h0;
      sram_wdata_r <= 32'h0;
    end else begin
      state_r      <= state_nxt_s;
      count_r      <= count_nxt_s;
      ready_r      <= push_s | rd_done_s;
      sram_we_r    <= sram_we_nxt_s;
      sram_re_r    <= sram_re_nxt_s;
      sram_addr_r  <= sram_addr_nxt_s;
      sram_wdata_r <= sram_wdata_nxt_s;
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      if (rd_done_s) begin
        rd_data_r <= sram_read_data64;
      end
    end
  end

  assign ready           = ready_r;
  assign rd_data         = rd_data_r;
  assign full            = (count_r == CNT_FULL);
  assign empty           = (count_r == CNT_ZERO);
  assign sram_write_en   = sram_we_r;
  assign sram_read_en    = sram_re_r;
  assign sram_address    = sram_addr_r;
  assign sram_write_data = sram_wdata_r;

endmodule

// File: tb/tb_sram_write_buffer.sv
// tb_sram_write_buffer
// Randomized and directed stimulus for sram_write_buffer, checked every cycle against a
// queue-based model of the buffer plus a word-addressed SRAM image.
module tb_sram_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic [63:0] rd_data;
  logic        full;
  logic        empty;
  logic        sram_write_en;
  logic        sram_read_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data64 = 64'h0;
  logic        sram_ready = 1'b0;

  always #5 clk = ~clk;

  sram_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
    .ready(ready), .rd_data(rd_data), .full(full), .empty(empty),
    .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data64(sram_read_data64), .sram_ready(sram_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef enum int { DS_NONE, DS_WR, DS_RD } ds_t;

  wr_t         q[$];
  wr_t         wlog[$];
  ds_t         m_ds = DS_NONE;
  logic        m_ready = 1'b0;
  logic [63:0] m_rd_data = 64'h0;
  logic [31:0] m_rd_addr = 32'h0;
  logic [63:0] mem [logic [31:0]];

  bit          chk_en = 1'b0;
  bit          auto_resp = 1'b0;
  int          pulse_req = 0;
  int          pulse_done = 0;

  bit          mp_pop, mp_rdone, mp_acc;
  logic [63:0] mp_line;

  function automatic logic [63:0] line_of(logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 1;
    if (mem.exists(idx)) return mem[idx];
    return 64'h0;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes are a queue, downstream is "none / write head / read".
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      m_ds = DS_NONE;
      m_ready = 1'b0;
      m_rd_data = 64'h0;
      m_rd_addr = 32'h0;
    end else begin
      mp_pop   = (m_ds == DS_WR) && sram_ready;
      mp_rdone = (m_ds == DS_RD) && sram_ready;
      mp_acc   = wr_en && !rd_en && !m_ready && ((q.size() < DEPTH) || mp_pop);
      if (mp_rdone) m_rd_data = sram_read_data64;
      case (m_ds)
        DS_WR: if (mp_pop) begin
          mp_line = line_of(q[0].a);
          if (q[0].a[0]) mp_line[63:32] = q[0].d;
          else mp_line[31:0] = q[0].d;
          mem[q[0].a >> 1] = mp_line;
          void'(q.pop_front());
          m_ds = DS_NONE;
        end
        DS_RD: if (mp_rdone) m_ds = DS_NONE;
        default: begin
          if (q.size() > 0) m_ds = DS_WR;
          else if (rd_en && !m_ready) begin
            m_ds = DS_RD;
            m_rd_addr = address;
          end
        end
      endcase
      if (mp_acc) q.push_back({address, wdata});
      m_ready = mp_acc || mp_rdone;
    end
  end

  // SRAM controller stand-in: completion pulses driven from the model's view of the bus.
  initial forever begin
    @(posedge clk);
    #4;
    if (pulse_req != pulse_done) begin
      sram_ready = 1'b1;
      pulse_done = pulse_req;
    end else if (auto_resp) begin
      if (m_ds != DS_NONE) sram_ready = ($urandom_range(0, 2) == 0);
      else sram_ready = ($urandom_range(0, 9) == 0);
    end else begin
      sram_ready = 1'b0;
    end
    if (m_ds == DS_RD) sram_read_data64 = line_of(m_rd_addr);
    else sram_read_data64 = {$urandom, $urandom};
  end

  // Cycle compare against the model, plus a log of completed downstream writes.
  initial forever begin
    @(negedge clk);
    if (rst && chk_en) begin
      check("ready", ready, m_ready);
      check("full", full, (q.size() == DEPTH));
      check("empty", empty, (q.size() == 0));
      check("sram_write_en", sram_write_en, (m_ds == DS_WR));
      check("sram_read_en", sram_read_en, (m_ds == DS_RD));
      check("rd_data", rd_data, m_rd_data);
      if (m_ds == DS_WR) begin
        check("wr_addr", sram_address, q[0].a);
        check("wr_data", sram_write_data, q[0].d);
      end else if (m_ds == DS_RD) begin
        check("rd_addr", sram_address, m_rd_addr);
      end
      if (sram_write_en && sram_ready) wlog.push_back({sram_address, sram_write_data});
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (k == 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ready expected ready within 300 cycles", nm);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d);
    wr_en = 1'b1; rd_en = 1'b0; address = a; wdata = d;
    wait_ready("write");
    wr_en = 1'b0;
  endtask

  task automatic do_read(logic [31:0] a, logic both);
    rd_en = 1'b1; wr_en = both; address = a; wdata = $urandom;
    wait_ready("read");
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 500; k++) begin
      if (empty && !sram_write_en) break;
      idle(1);
    end
    if (k == 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got empty=%0b expected empty=1", empty);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_log [3];
    exp_log[0] = {32'h30, 32'h1};
    exp_log[1] = {32'h31, 32'h2};
    exp_log[2] = {32'h30, 32'h3};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", ready, 1'b0);
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_we", sram_write_en, 1'b0);
    check("rst_re", sram_read_en, 1'b0);
    check("rst_addr", sram_address, 32'h0);
    check("rst_wdata", sram_write_data, 32'h0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Single write reaches SRAM unchanged
    auto_resp = 1'b0;
    do_write(32'h10, 32'hA5A5A5A5);
    check("t2_we", sram_write_en, 1'b1);
    check("t2_addr", sram_address, 32'h10);
    check("t2_data", sram_write_data, 32'hA5A5A5A5);
    idle(2);
    check("t2_hold_we", sram_write_en, 1'b1);
    check("t2_hold_addr", sram_address, 32'h10);
    pulse_req++;
    idle(1);
    check("t2_empty", empty, 1'b1);
    check("t2_we_low", sram_write_en, 1'b0);

    // Ordering of repeated addresses
    auto_resp = 1'b1;
    wlog.delete();
    do_write(32'h30, 32'h1);
    do_write(32'h31, 32'h2);
    do_write(32'h30, 32'h3);
    wait_drain();
    check("t5_count", wlog.size(), 3);
    for (int i = 0; i < 3; i++) check("t5_order", wlog[i], exp_log[i]);

    // Read after write
    do_write(32'h20, 32'h11111111);
    do_read(32'h20, 1'b0);
    check("t4_rd_data", rd_data, 64'h00000000_11111111);
    check("t4_ready_once", ready, 1'b0);

    // Fill, stall while full, then push and pop together across the pointer wrap
    wait_drain();
    auto_resp = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_write(32'h40 + i, 32'hC0DE0000 + i);
    check("t3_full", full, 1'b1);
    check("t3_head_addr", sram_address, 32'h40);
    wr_en = 1'b1; address = 32'h44; wdata = 32'hC0DE0004;
    repeat (4) begin
      @(negedge clk);
      check("t3_stall_ready", ready, 1'b0);
      check("t3_stall_full", full, 1'b1);
    end
    @(posedge clk);
    #2;
    pulse_req++;
    idle(1);
    check("t6_ready", ready, 1'b1);
    check("t6_full", full, 1'b1);
    check("t6_we_gap", sram_write_en, 1'b0);
    wr_en = 1'b0;
    idle(1);
    check("t6_next_addr", sram_address, 32'h41);
    check("t6_next_data", sram_write_data, 32'hC0DE0001);
    auto_resp = 1'b1;
    wait_drain();
    do_read(32'h44, 1'b0);
    check("t6_wrap_line", rd_data, 64'h00000000_C0DE0004);
    do_read(32'h40, 1'b0);
    check("t6_line40", rd_data, 64'hC0DE0001_C0DE0000);

    // Asynchronous reset in the middle of a write drain
    wait_drain();
    auto_resp = 1'b0;
    do_write(32'h50, 32'hDEAD0000);
    do_write(32'h51, 32'hDEAD0001);
    do_write(32'h52, 32'hDEAD0002);
    check("t1_we_before", sram_write_en, 1'b1);
    check("t1_empty_before", empty, 1'b0);
    rst = 1'b0;
    #1;
    check("t1_ready", ready, 1'b0);
    check("t1_rd_data", rd_data, 64'h0);
    check("t1_we", sram_write_en, 1'b0);
    check("t1_re", sram_read_en, 1'b0);
    check("t1_addr", sram_address, 32'h0);
    check("t1_wdata", sram_write_data, 32'h0);
    check("t1_empty", empty, 1'b1);
    check("t1_full", full, 1'b0);
    idle(2);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t1_no_we", sram_write_en, 1'b0);
      check("t1_still_empty", empty, 1'b1);
    end
    @(posedge clk);
    #2;
    auto_resp = 1'b1;
    do_read(32'h50, 1'b0);
    check("t1_discarded", rd_data, 64'h0);

    // Randomized traffic
    repeat (400) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 15);
      if (r < 65) do_write(a, $urandom);
      else if (r < 93) do_read(a, 1'b0);
      else do_read(a, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_drain();
    check("final_empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
